// File: rtl/usr_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and parity helper.
package usr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } state_t;

   localparam int PAR_W = 32;

   // Parity bit a transmitter would send for word; callers zero-extend narrower words.
   function automatic logic par_calc(input logic [PAR_W-1:0] word, input logic odd);
      return (^word) ^ odd;
   endfunction

endpackage

// File: rtl/rx_out_buf.sv
// One-entry valid/ready holding register; a new word is dropped (overrun pulse) while the
// buffered word is still pending and not being accepted on the same edge.
module rx_out_buf #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         ready,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic         overrun
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load) begin
            if (!valid || ready) begin
               dout  <= din;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, n data bits LSB-first, parity, stop; good words are
// handed to a one-entry valid/ready buffer together with their parity-error flag.
module serial_frame_rx
   import usr_pkg::*;
#(
   parameter int n          = 4,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bit_en,
   input  logic         ser_in,
   input  logic         ready,
   output logic [n-1:0] data,
   output logic         valid,
   output logic         par_err,
   output logic         frame_err,
   output logic         overrun,
   output logic         busy
);

   localparam int CNT_W = $clog2(n);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [n-1:0]     sreg;
   logic             pbit;
   logic             load;
   logic             par_bad;
   logic [n:0]       buf_q;

   // A good stop bit loads the buffer on the very edge that samples it.
   assign load    = bit_en && (state == STOP) && ser_in;
   assign par_bad = (pbit != par_calc(PAR_W'(sreg), PARITY_ODD));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sreg      <= '0;
         pbit      <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (bit_en) begin
            case (state)
               IDLE: begin
                  if (!ser_in) begin
                     state <= DATA;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end
               end
               DATA: begin
                  sreg[cnt] <= ser_in;
                  if (cnt == CNT_W'(n - 1)) begin
                     state <= PAR;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               PAR: begin
                  pbit  <= ser_in;
                  state <= STOP;
               end
               STOP: begin
                  // A low stop bit is a framing error, never a fresh start bit.
                  frame_err <= !ser_in;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   rx_out_buf #(
      .W(n + 1)
   ) u_out_buf (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .din    ({par_bad, sreg}),
      .ready  (ready),
      .dout   (buf_q),
      .valid  (valid),
      .overrun(overrun)
   );

   assign data    = buf_q[n-1:0];
   assign par_err = buf_q[n];

endmodule
